tt_um_jleugeri_ttt_router: RTL and testbench
============================================

TT_UM_JLEUGERI_TTT_ROUTER -- requirements
Module: tt_um_jleugeri_ttt_router

Interface
REQ-001 Parameter NUM_PROCESSORS, default 4, number of processors; IDW = $clog2(NUM_PROCESSORS).
REQ-002 Parameter NUM_CONNECTIONS, default NUM_PROCESSORS*NUM_PROCESSORS, connection-memory depth; CW = $clog2(NUM_CONNECTIONS+1).
REQ-003 Parameter NEW_TOKENS_BITS, default 4, signed token-weight width.
REQ-004 Parameter QUEUE_DEPTH, default 4 (power of 2, >=2), source-event FIFO depth.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 src_valid / src_ready  in / out  1 / 1  source-event handshake.
REQ-008 source_id  in  IDW  processor that emitted the event.
REQ-009 valid_out / ready_out  out / in  1 / 1  connection-output handshake.
REQ-010 target_id  out  IDW; new_good_tokens, new_bad_tokens  out  NEW_TOKENS_BITS signed each.
REQ-011 done  out  1  one-cycle pulse when a source's fan-out is finished.
REQ-012 busy  out  1  high when FIFO non-empty or FSM not IDLE.
REQ-013 prog_we  in  1; prog_sel  in  1 (0=indptr, 1=connection); prog_addr  in  CW; prog_data  in  max(CW, IDW+2*NEW_TOKENS_BITS).
REQ-014 prog_ready  out  1  equals !busy.

Function
REQ-015 Memories: indptr[0..NUM_PROCESSORS] (CW bits); per connection {index, good, bad}; contents SHALL NOT be cleared by reset.
REQ-016 Write occurs at edge when prog_we && prog_ready; sel=0 writes indptr[prog_addr] = prog_data[CW-1:0]; sel=1 writes connection[prog_addr] = {index, good, bad} from prog_data MSB->LSB; out-of-range addresses ignored.
REQ-017 prog_we while busy SHALL be ignored, no memory change.
REQ-018 src_ready = FIFO not full; event pushed at edge when src_valid && src_ready.
REQ-019 FIFO has no bypass; push and pop in same cycle allowed, occupancy unchanged.
REQ-020 FSM states IDLE, LOAD, EMIT.
REQ-021 IDLE: FIFO non-empty -> pop head into src register, go LOAD; else stay.
REQ-022 LOAD: start = indptr[src], end = indptr[src+1]; if end <= start -> done=1 next cycle, go IDLE; else register connection[start] onto outputs, valid_out=1, addr=start, go EMIT.
REQ-023 EMIT: outputs and valid_out SHALL hold stable while ready_out=0.
REQ-024 EMIT on handshake: if addr+1 == end -> valid_out=0, done=1 next cycle, go IDLE; else addr+1, register connection[addr+1].
REQ-025 Latency: event pushed at edge N -> valid_out high after edge N+2 (FIFO empty, FSM IDLE); empty row -> done high after edge N+2.
REQ-026 Back-to-back: after done-producing transition, next queued event popped in the IDLE cycle that follows.
REQ-027 end or start > NUM_CONNECTIONS -> treated as empty row (done only, no outputs).
REQ-028 done SHALL be exactly one cycle per popped event, never asserted with valid_out.
REQ-029 Weights passed through unmodified as signed two's complement.

Reset
REQ-030 Reset: FSM IDLE, FIFO empty, valid_out=0, done=0, busy=0, src_ready=1, prog_ready=1; target_id and token outputs 0.
REQ-031 Reset mid-EMIT or with FIFO occupied SHALL discard all pending work; memories retained.
REQ-032 Reset has priority over every handshake and write in the same cycle.

Verification
REQ-033 Program indptr={0,2,2,3,3}, conn0={1,+3,-1}, conn1={2,-8,7}, conn2={0,1,0}; push src 0, ready_out=1 -> outputs (1,3,-1),(2,-8,7) on consecutive cycles, done one cycle after.
REQ-034 Same program, push src 1 -> no valid_out, done pulses exactly once 2 cycles after push.
REQ-035 Push src 0 with ready_out held 0 for 5 cycles -> (1,3,-1) held stable 5 cycles, then sequence as REQ-033.
REQ-036 Push 5 events with QUEUE_DEPTH=4, FSM stalled -> src_ready drops after 4th push; all 4 processed in order with 4 done pulses.
REQ-037 prog_we during EMIT writing conn0={3,5,5} -> ignored; later replay of src 0 still yields (1,3,-1).
REQ-038 Assert reset mid-EMIT with 2 events queued -> valid_out=0 next cycle, busy=0, no done; subsequent src 2 push yields (0,1,0).

Source files
------------

// File: rtl/tt_um_jleugeri_ttt_router.sv
// Event router: expands each queued source event into its programmed
// fan-out list of {target, good, bad} connections.
module tt_um_jleugeri_ttt_router #(
    parameter int NUM_PROCESSORS  = 4,
    parameter int NUM_CONNECTIONS = NUM_PROCESSORS * NUM_PROCESSORS,
    parameter int NEW_TOKENS_BITS = 4,
    parameter int QUEUE_DEPTH     = 4,
    localparam int IDW = $clog2(NUM_PROCESSORS),
    localparam int CW  = $clog2(NUM_CONNECTIONS + 1),
    localparam int EW  = IDW + 2 * NEW_TOKENS_BITS,
    localparam int PDW = (CW > EW) ? CW : EW
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              src_valid,
    output logic                              src_ready,
    input  logic [IDW-1:0]                    source_id,
    output logic                              valid_out,
    input  logic                              ready_out,
    output logic [IDW-1:0]                    target_id,
    output logic signed [NEW_TOKENS_BITS-1:0] new_good_tokens,
    output logic signed [NEW_TOKENS_BITS-1:0] new_bad_tokens,
    output logic                              done,
    output logic                              busy,
    input  logic                              prog_we,
    input  logic                              prog_sel,
    input  logic [CW-1:0]                     prog_addr,
    input  logic [PDW-1:0]                    prog_data,
    output logic                              prog_ready
);
    localparam int QAW = $clog2(QUEUE_DEPTH);
    localparam int IAW = $clog2(NUM_PROCESSORS + 1);
    localparam int CAW = $clog2(NUM_CONNECTIONS);
    localparam int NTB = NEW_TOKENS_BITS;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t state, state_nx;

    logic [CW-1:0]  indptr   [NUM_PROCESSORS + 1];
    logic [EW-1:0]  conn_mem [NUM_CONNECTIONS];
    logic [IDW-1:0] fifo_mem [QUEUE_DEPTH];

    logic [QAW:0]   wr_ptr, rd_ptr;
    logic           empty, full, push, pop, load, step, fin;
    logic [IDW-1:0] src;
    logic [IDW:0]   src_ix, src_ix_nx;
    logic [CW-1:0]  addr, addr_nx, end_r, row_start, row_end;
    logic           row_empty, last;
    logic [EW-1:0]  conn_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[QAW] != rd_ptr[QAW]) &&
                   (wr_ptr[QAW-1:0] == rd_ptr[QAW-1:0]);
    assign src_ready  = !full;
    assign push       = src_valid && src_ready;
    assign busy       = !empty || (state != IDLE);
    assign prog_ready = !busy;

    assign src_ix    = {1'b0, src};
    assign src_ix_nx = src_ix + (IDW + 1)'(1);
    assign row_start = indptr[src_ix];
    assign row_end   = indptr[src_ix_nx];
    // Rows pointing past the connection memory are treated as empty
    assign row_empty = (row_end <= row_start) ||
                       (row_end > CW'(NUM_CONNECTIONS)) ||
                       (row_start > CW'(NUM_CONNECTIONS));
    assign addr_nx = addr + CW'(1);
    assign last    = (addr_nx == end_r);
    assign conn_rd = load ? conn_mem[row_start[CAW-1:0]]
                          : conn_mem[addr_nx[CAW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop  = 1'b0;
        load = 1'b0;
        step = 1'b0;
        fin  = 1'b0;
        unique case (state)
            IDLE: if (!empty) begin
                pop      = 1'b1;
                state_nx = LOAD;
            end
            LOAD: if (row_empty) begin
                fin      = 1'b1;
                state_nx = IDLE;
            end else begin
                load     = 1'b1;
                state_nx = EMIT;
            end
            EMIT: if (ready_out) begin
                if (last) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            src             <= '0;
            addr            <= '0;
            end_r           <= '0;
            valid_out       <= 1'b0;
            done            <= 1'b0;
            target_id       <= '0;
            new_good_tokens <= '0;
            new_bad_tokens  <= '0;
        end else begin
            done <= fin;
            if (push) wr_ptr <= wr_ptr + (QAW + 1)'(1);
            if (pop) begin
                src    <= fifo_mem[rd_ptr[QAW-1:0]];
                rd_ptr <= rd_ptr + (QAW + 1)'(1);
            end
            if (load) begin
                addr  <= row_start;
                end_r <= row_end;
            end
            if (step) addr <= addr_nx;
            if (load || step) begin
                valid_out       <= 1'b1;
                target_id       <= conn_rd[EW-1 -: IDW];
                new_good_tokens <= conn_rd[2*NTB-1 -: NTB];
                new_bad_tokens  <= conn_rd[NTB-1:0];
            end
            if (fin) valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[QAW-1:0]] <= source_id;
    end

    // Program memories survive reset; reset only blocks the write
    always_ff @(posedge clk) begin
        if (!reset && prog_we && prog_ready) begin
            if (!prog_sel) begin
                if (prog_addr <= CW'(NUM_PROCESSORS))
                    indptr[prog_addr[IAW-1:0]] <= prog_data[CW-1:0];
            end else if (prog_addr < CW'(NUM_CONNECTIONS)) begin
                conn_mem[prog_addr[CAW-1:0]] <= prog_data[EW-1:0];
            end
        end
    end
endmodule

// File: tb/tb_tt_um_jleugeri_ttt_router.sv
// Directed table-driven bench for the connection router.
module tb_tt_um_jleugeri_ttt_router;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic src_valid = 1'b0;
    logic ready_out = 1'b1;
    logic prog_we = 1'b0;
    logic prog_sel = 1'b0;
    logic [1:0] source_id = '0;
    logic [4:0] prog_addr = '0;
    logic [9:0] prog_data = '0;
    logic src_ready, valid_out, done, busy, prog_ready;
    logic [1:0] target_id;
    logic signed [3:0] new_good_tokens, new_bad_tokens;

    tt_um_jleugeri_ttt_router dut (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_ready(src_ready),
        .source_id(source_id),
        .valid_out(valid_out), .ready_out(ready_out),
        .target_id(target_id),
        .new_good_tokens(new_good_tokens),
        .new_bad_tokens(new_bad_tokens),
        .done(done), .busy(busy),
        .prog_we(prog_we), .prog_sel(prog_sel),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_ready(prog_ready)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] C0A = 10'b01_0011_1111;
    localparam logic [9:0] C0B = 10'b10_1000_0111;
    localparam logic [9:0] C2  = 10'b00_0001_0000;

    typedef struct {
        logic [1:0] src;
        int stall;
        int n;
        logic [9:0] o0;
        logic [9:0] o1;
        int first;
        int dc;
    } vec_t;

    typedef struct {
        logic sel;
        int addr;
        logic [9:0] data;
    } wr_t;

    int total = 0;
    int bad = 0;
    logic [9:0] got[$];
    int dcnt, dcyc, fcyc, ovl, unstable;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic sel, input int a, input logic [9:0] d);
        prog_we = 1'b1;
        prog_sel = sel;
        prog_addr = a[4:0];
        prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic push(input logic [1:0] s);
        src_valid = 1'b1;
        source_id = s;
        tick();
        src_valid = 1'b0;
    endtask

    task automatic collect(input int ncyc, input int stall);
        int sc;
        bit hv;
        logic [9:0] held, cur;
        sc = 0;
        hv = 0;
        held = '0;
        got.delete();
        dcnt = 0; dcyc = -1; fcyc = -1; ovl = 0; unstable = 0;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            cur = {target_id, new_good_tokens, new_bad_tokens};
            if (done) begin
                dcnt++;
                dcyc = c;
                if (valid_out) ovl++;
            end
            if (valid_out) begin
                if (fcyc < 0) fcyc = c;
                if (sc < stall) begin
                    if (hv && held !== cur) unstable++;
                    held = cur;
                    hv = 1;
                    sc++;
                    ready_out = 1'b0;
                end else begin
                    ready_out = 1'b1;
                    got.push_back(cur);
                end
            end else begin
                ready_out = 1'b1;
            end
        end
    endtask

    function automatic int g(input int i);
        return (got.size() > i) ? int'(got[i]) : -1;
    endfunction

    vec_t vt[6];
    wr_t  pw[8];
    logic [9:0] exp5[5];

    initial begin
        vt[0] = '{2'd0, 0, 2, C0A, C0B, 2, 4};
        vt[1] = '{2'd1, 0, 0, 10'd0, 10'd0, -1, 2};
        vt[2] = '{2'd2, 0, 1, C2, 10'd0, 2, 3};
        vt[3] = '{2'd3, 0, 0, 10'd0, 10'd0, -1, 2};
        vt[4] = '{2'd0, 5, 2, C0A, C0B, 2, 9};
        vt[5] = '{2'd0, 1, 2, C0A, C0B, 2, 5};
        pw[0] = '{1'b0, 0, 10'd0};
        pw[1] = '{1'b0, 1, 10'd2};
        pw[2] = '{1'b0, 2, 10'd2};
        pw[3] = '{1'b0, 3, 10'd3};
        pw[4] = '{1'b0, 4, 10'd3};
        pw[5] = '{1'b1, 0, C0A};
        pw[6] = '{1'b1, 1, C0B};
        pw[7] = '{1'b1, 2, C2};
        exp5 = '{C0A, C0B, C2, C0A, C0B};

        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_src_ready", int'(src_ready), 1);
        chk("rst_prog_ready", int'(prog_ready), 1);
        chk("rst_outs", int'({target_id, new_good_tokens, new_bad_tokens}), 0);

        foreach (pw[i]) wr(pw[i].sel, pw[i].addr, pw[i].data);

        // Write attempted while emitting must be dropped
        ready_out = 1'b0;
        push(2'd0);
        tick(); tick(); tick();
        chk("emit_valid", int'(valid_out), 1);
        chk("emit_prog_ready", int'(prog_ready), 0);
        wr(1'b1, 0, {2'b11, 4'd5, 4'd5});
        collect(14, 0);
        chk("wbusy_n", got.size(), 2);
        chk("wbusy_o0", g(0), int'(C0A));

        foreach (vt[i]) begin
            push(vt[i].src);
            collect(14, vt[i].stall);
            chk($sformatf("v%0d_n", i), got.size(), vt[i].n);
            if (vt[i].n > 0) begin
                chk($sformatf("v%0d_o0", i), g(0), int'(vt[i].o0));
                chk($sformatf("v%0d_first", i), fcyc, vt[i].first);
            end
            if (vt[i].n > 1)
                chk($sformatf("v%0d_o1", i), g(1), int'(vt[i].o1));
            chk($sformatf("v%0d_dcnt", i), dcnt, 1);
            chk($sformatf("v%0d_dcyc", i), dcyc, vt[i].dc);
            chk($sformatf("v%0d_ovl", i), ovl, 0);
            chk($sformatf("v%0d_stable", i), unstable, 0);
            chk($sformatf("v%0d_idle", i), int'(busy), 0);
        end

        // Fill the FIFO behind a stalled fan-out
        ready_out = 1'b0;
        push(2'd0);
        tick(); tick(); tick();
        push(2'd2);
        push(2'd1);
        push(2'd3);
        chk("q3_ready", int'(src_ready), 1);
        push(2'd0);
        chk("q4_full", int'(src_ready), 0);
        src_valid = 1'b1;
        source_id = 2'd2;
        tick();
        tick();
        chk("q5_blocked", int'(src_ready), 0);
        src_valid = 1'b0;
        collect(40, 0);
        chk("q_n", got.size(), 5);
        foreach (exp5[i]) chk($sformatf("q_o%0d", i), g(i), int'(exp5[i]));
        chk("q_dcnt", dcnt, 5);
        chk("q_ovl", ovl, 0);

        // Reset mid-emit with work queued, plus colliding write/push
        ready_out = 1'b0;
        push(2'd0);
        tick(); tick(); tick();
        push(2'd1);
        push(2'd2);
        reset = 1'b1;
        prog_we = 1'b1;
        prog_sel = 1'b1;
        prog_addr = 5'd2;
        prog_data = 10'h3FF;
        src_valid = 1'b1;
        source_id = 2'd3;
        tick();
        reset = 1'b0;
        prog_we = 1'b0;
        src_valid = 1'b0;
        chk("mr_valid", int'(valid_out), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_done", int'(done), 0);
        chk("mr_src_ready", int'(src_ready), 1);
        collect(6, 0);
        chk("mr_quiet_n", got.size(), 0);
        chk("mr_quiet_done", dcnt, 0);
        push(2'd2);
        collect(14, 0);
        chk("mr_src2_n", got.size(), 1);
        chk("mr_src2_o0", g(0), int'(C2));
        chk("mr_src2_dcnt", dcnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
